// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared N-bit ripple-carry add/subtract chain.
// Optional ADDSUB_ABS_EN adds a registered absolute-difference output; otherwise res_abs_o mirrors res_s_o.
module addsub_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic         req0_op_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    input  logic         req1_op_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         res_id_o,
    output logic [N-1:0] res_s_o,
    output logic         res_cout_o,
    output logic [N-1:0] res_abs_o,
    output logic         busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         ptr_q, ptr_d;
    logic [N-1:0] a_q, b_q;
    logic         op_q, id_q;
    logic [N-1:0] res_s_q;
    logic         res_cout_q, res_id_q;
    logic         grant_id, accept, idle_ok;
    logic [N-1:0] b_eff, sum;
    logic [N:0]   carry;

    // Ready is gated by rst so both readies read 0 while reset is held.
    assign grant_id     = (req0_valid_i && req1_valid_i) ? ~ptr_q : req1_valid_i;
    assign idle_ok      = (state_q == S_IDLE) && !rst;
    assign req0_ready_o = idle_ok && req0_valid_i && !grant_id;
    assign req1_ready_o = idle_ok && req1_valid_i && grant_id;
    assign accept       = req0_ready_o || req1_ready_o;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    ptr_d   = grant_id;
                end
            end
            S_EXEC:  state_d = S_HOLD;
            S_HOLD:  if (res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Explicit full-adder chain; subtract is a + ~b + 1.
    always_comb begin
        b_eff    = op_q ? ~b_q : b_q;
        carry    = '0;
        sum      = '0;
        carry[0] = op_q;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a_q[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (a_q[i] & b_eff[i]) | (carry[i] & (a_q[i] ^ b_eff[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            id_q       <= 1'b0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                a_q  <= grant_id ? req1_a_i : req0_a_i;
                b_q  <= grant_id ? req1_b_i : req0_b_i;
                op_q <= grant_id ? req1_op_i : req0_op_i;
                id_q <= grant_id;
            end
            if (state_q == S_EXEC) begin
                res_s_q    <= sum;
                res_cout_q <= carry[N];
                res_id_q   <= id_q;
            end
        end
    end

`ifdef ADDSUB_ABS_EN
    logic [N-1:0] abs_d, res_abs_q;

    // A borrow on subtract means the result is negative; negate for magnitude.
    assign abs_d = (op_q && !carry[N]) ? (~sum + 1'b1) : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_abs_q <= '0;
        end else if (state_q == S_EXEC) begin
            res_abs_q <= abs_d;
        end
    end

    assign res_abs_o = res_abs_q;
`else
    assign res_abs_o = res_s_q;
`endif

    assign res_valid_o = (state_q == S_HOLD);
    assign busy_o      = (state_q != S_IDLE);
    assign res_s_o     = res_s_q;
    assign res_cout_o  = res_cout_q;
    assign res_id_o    = res_id_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: arbitration, datapath corner cases, result hold and reset.
module tb_addsub_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_op;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_op;
    logic [N-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_id, res_cout, busy;
    logic [N-1:0] res_s, res_abs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_op_i    (req0_op),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_op_i    (req1_op),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_id_o     (res_id),
        .res_s_o      (res_s),
        .res_cout_o   (res_cout),
        .res_abs_o    (res_abs),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single-requester transaction with hand-computed expectations.
    task automatic run_op(input logic id, input logic [N-1:0] a, input logic [N-1:0] b, input logic op,
                          input logic [N-1:0] es, input logic ec, input logic [N-1:0] eabs, input string tag);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk({tag, "_rdy0"}, req0_ready, !id);
        chk({tag, "_rdy1"}, req1_ready, id);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_busy"}, busy, 1'b1);
        chk({tag, "_exec_vld"}, res_valid, 1'b0);
        tick();
        chk({tag, "_vld"}, res_valid, 1'b1);
        chk({tag, "_s"}, res_s, es);
        chk({tag, "_cout"}, res_cout, ec);
        chk({tag, "_abs"}, res_abs, eabs);
        chk({tag, "_id"}, res_id, id);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_done_vld"}, res_valid, 1'b0);
        chk({tag, "_done_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = 1'b0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = 1'b0;
        res_ready = 1'b0;
        tick();
        tick();
        // Reset state, with both requesters already asking.
        chk("rst_vld", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy0", req0_ready, 1'b0);
        chk("rst_rdy1", req1_ready, 1'b0);
        chk("rst_s", res_s, 32'h0);
        chk("rst_cout", res_cout, 1'b0);
        chk("rst_abs", res_abs, 32'h0);
        chk("rst_id", res_id, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        run_op(1'b0, 32'h10, 32'h08, 1'b1, 32'h8, 1'b1, 32'h8, "sub_pos");
`ifdef ADDSUB_ABS_EN
        run_op(1'b1, 32'h08, 32'h10, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h8, "sub_neg");
`else
        run_op(1'b1, 32'h08, 32'h10, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, "sub_neg");
`endif

        // Continuous contention: grants alternate starting with req0.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd1; req1_op = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_rdy0", k), req0_ready, (k % 2) == 0);
            chk($sformatf("rr%0d_rdy1", k), req1_ready, (k % 2) == 1);
            tick();
            chk($sformatf("rr%0d_exec_rdy", k), {req0_ready, req1_ready}, 2'b00);
            tick();
            chk($sformatf("rr%0d_vld", k), res_valid, 1'b1);
            chk($sformatf("rr%0d_id", k), res_id, (k % 2) == 1);
            chk($sformatf("rr%0d_s", k), res_s, ((k % 2) == 0) ? 32'd3 : 32'd4);
            chk($sformatf("rr%0d_hold_rdy", k), {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b0;

        run_op(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 32'h0, "add_wrap");
        run_op(1'b0, 32'h10, 32'h10, 1'b1, 32'h0, 1'b1, 32'h0, "sub_eq");

        // Consumer stalls in HOLD while req1 waits.
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8; req0_op = 1'b0;
        #1;
        chk("hold_rdy0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_vld", k), res_valid, 1'b1);
            chk($sformatf("hold%0d_s", k), res_s, 32'd15);
            chk($sformatf("hold%0d_id", k), res_id, 1'b0);
            chk($sformatf("hold%0d_cout", k), res_cout, 1'b0);
            chk($sformatf("hold%0d_rdy", k), {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("hold_hs_rdy1", req1_ready, 1'b0);
        tick();
        res_ready = 1'b0;
        #1;
        chk("hold_after_vld", res_valid, 1'b0);
        chk("hold_after_rdy1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("hold_req1_vld", res_valid, 1'b1);
        chk("hold_req1_s", res_s, 32'd5);
        chk("hold_req1_id", res_id, 1'b1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset mid-operation, then a tie must go to req0 again.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 1'b0;
        #1;
        chk("arst_acc_rdy0", req0_ready, 1'b1);
        tick();
        chk("arst_exec_busy", busy, 1'b1);
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_op = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_vld", res_valid, 1'b0);
        chk("arst_rdy", {req0_ready, req1_ready}, 2'b00);
        tick();
        chk("arst_held_vld", res_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_tie_rdy0", req0_ready, 1'b1);
        chk("arst_tie_rdy1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("arst_res_vld", res_valid, 1'b1);
        chk("arst_res_id", res_id, 1'b0);
        chk("arst_res_s", res_s, 32'd2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Shares one N-bit ripple-carry add/subtract datapath between two requesters using round-robin arbitration and valid/ready handshakes. Each accepted request is registered, executed in one cycle on the shared full-adder chain, and held on a result port tagged with the requester ID until consumed. It sits between the lab ALU front-ends and the shared `rca_Nbit`/`subtractor_Nbit`-style adder chain. It is the single owner of that chain.

## Interface
- N, 32, operand and result width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_a, req0_b  in  N  requester 0 operands
- req0_op  in  1  0 = add (a+b), 1 = subtract (a-b)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- res_valid  out  1  result registers hold a valid result
- res_ready  in  1  consumer takes result when high with res_valid
- res_id  out  1  requester index that issued the result
- res_s  out  N  sum or difference, modulo 2^N
- res_cout  out  1  carry out; for subtract, 1 = no borrow (a >= b unsigned)
- res_abs  out  N  absolute difference (see Configuration)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - Arbiter picks the winner among the valid requesters.
  - Only the winner's ready is driven high; ready is combinational from state, valid signals and the priority pointer.
  - On accept: latch a, b, op and id; go to EXEC.
- Round robin:
  - A 1-bit pointer stores the last granted id.
  - If both requesters are valid, grant the one not last granted. If one is valid, grant it.
  - The pointer updates only on accept.
  - After reset the pointer is 1, so req0 wins the first tie.
- EXEC:
  - Drive the latched operands through the adder chain: b is inverted and cin = 1 for subtract, cin = 0 for add.
  - Register s, cout, id and abs; go to HOLD.
- HOLD:
  - res_valid = 1, and all res_* are stable.
  - On res_ready, go to IDLE. No request is accepted in the same cycle.
- No ready is asserted outside IDLE.
- Width rules:
  - Add: res_s = (a+b) mod 2^N; res_cout = bit N.
  - Subtract: res_s = (a + ~b + 1) mod 2^N.
  - a == b gives res_s = 0 and res_cout = 1.

## Timing
- Reset values: res_valid, res_id, res_s, res_cout, res_abs, busy and both readies are 0. State is IDLE; pointer is 1.
- rst is asserted asynchronously:
  - Any in-flight operation is discarded and res_valid drops immediately.
  - Operands are not replayed.
- Latency: accept at edge t → EXEC during cycle t+1 → res_valid high from edge t+2.
- Maximum throughput is one operation per 3 cycles with res_ready tied high.
- Valid/ready rules:
  - Requesters must hold valid, operands and op stable until accepted.
  - The block never drops res_valid without res_ready, except on reset.
- Simultaneous events:
  - Both valid in IDLE: exactly one ready is high.
  - res_ready while not in HOLD: ignored.

## Configuration
- ADDSUB_ABS_EN defined:
  - For subtract with res_cout = 0, res_abs = (~res_s + 1) mod 2^N. Otherwise res_abs = res_s.
  - res_abs is computed in EXEC and registered with res_s.
- Not defined: res_abs is tied to res_s and the negation logic is omitted.

## Test plan
- N=32; req0 subtract 0x10 − 0x08 → res_valid 2 cycles after accept; res_s=0x00000008, res_cout=1, res_abs=0x00000008, res_id=0.
- req1 subtract 0x08 − 0x10 → res_s=0xFFFFFFF8, res_cout=0. res_abs=0x00000008 with ADDSUB_ABS_EN, 0xFFFFFFF8 without.
- Both valid continuously, res_ready=1 → grants alternate 0,1,0,1 starting with 0; each requester's ready is high only in its grant cycle.
- Add 0xFFFFFFFF + 0x00000001 → res_s=0, res_cout=1. Equal subtract 0x10 − 0x10 → res_s=0, res_cout=1, res_abs=0.
- Hold res_ready=0 for 5 cycles in HOLD → res_valid and res_* stable, both readies 0, and a pending req1 is not accepted until 1 cycle after the res_ready handshake.
- Assert rst during EXEC → res_valid, busy and readies go to 0 immediately. After release, the tie grants req0 first.
